// File: rtl/a2s_rd_arbiter.sv
// a2s_rd_arbiter: shares one AXI read port between two A2S stream channels.
// Round-robin grant, single fixed-length burst per grant, R beats steered to
// the winning channel with a shared beat index, RLAST checked against the count.
module a2s_rd_arbiter #(
   parameter int BURST_LEN  = 16,  // beats per burst, power of two, 2..16
   parameter int ADDR_ALIGN = 2    // low address bits forced to zero
) (
   input  logic        AXI_clk,
   input  logic        rst,
   // channel side
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] req_addr0,
   input  logic [31:0] req_addr1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rd_en0,
   output logic        rd_en1,
   output logic [3:0]  rd_idx,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic        busy,
   // AXI read master side
   output logic [31:0] AXI_raddr,
   output logic [3:0]  AXI_arlen,
   output logic        AXI_arvalid,
   input  logic        AXI_arready,
   input  logic        AXI_rvalid,
   input  logic        AXI_rlast,
   output logic        AXI_rready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [3:0]  LAST_IDX   = 4'(BURST_LEN - 1);
   localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ADDR_ALIGN) - 32'd1);

   state_t      state_q, state_d;
   logic        sel_q, sel_d;        // channel owning the current burst
   logic        rr_ptr_q, rr_ptr_d;  // channel preferred on a tie
   logic [31:0] raddr_q, raddr_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic [3:0]  cnt_q, cnt_d;        // beat counter within the burst
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  done_q, done_d;
   logic [1:0]  err_q, err_d;

   logic        pick;      // channel chosen in IDLE
   logic        beat;      // accepted R beat
   logic        last_cnt;  // counter sits on the final beat of the burst

   assign pick     = (req0 & req1) ? rr_ptr_q : req1;
   assign beat     = AXI_rvalid & rready_q;
   assign last_cnt = (cnt_q == LAST_IDX);

   // Next-state and output decode for the IDLE/ADDR/DATA sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d   = state_q;
      sel_d     = sel_q;
      rr_ptr_d  = rr_ptr_q;
      raddr_d   = raddr_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      cnt_d     = cnt_q;
      gnt_d     = 2'b00;
      done_d    = 2'b00;
      err_d     = 2'b00;

      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               sel_d     = pick;
               raddr_d   = (pick ? req_addr1 : req_addr0) & ALIGN_MASK;
               arvalid_d = 1'b1;
               state_d   = ADDR;
            end
         end

         ADDR: begin
            // Requests are ignored here: an issued AR is never withdrawn.
            if (AXI_arready) begin
               arvalid_d    = 1'b0;
               rready_d     = 1'b1;
               gnt_d[sel_q] = 1'b1;
               rr_ptr_d     = ~sel_q;
               cnt_d        = 4'd0;
               state_d      = DATA;
            end
         end

         DATA: begin
            if (beat) begin
               cnt_d = last_cnt ? 4'd0 : cnt_q + 4'd1;
               // Burst ends on the counted final beat or on an early RLAST;
               // either disagreement between count and RLAST is an error.
               if (last_cnt | AXI_rlast) begin
                  rready_d      = 1'b0;
                  done_d[sel_q] = 1'b1;
                  err_d[sel_q]  = last_cnt ? ~AXI_rlast : 1'b1;
                  state_d       = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge AXI_clk or posedge rst) begin
      // NOTE: the reset branch is asynchronous so outputs drop mid-burst without a clock edge.
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         rr_ptr_q  <= 1'b0;
         raddr_q   <= 32'd0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         cnt_q     <= 4'd0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         err_q     <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         state_q   <= state_d;
         sel_q     <= sel_d;
         rr_ptr_q  <= rr_ptr_d;
         raddr_q   <= raddr_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign gnt0        = gnt_q[0];
   assign gnt1        = gnt_q[1];
   assign done0       = done_q[0];
   assign done1       = done_q[1];
   assign err0        = err_q[0];
   assign err1        = err_q[1];
   assign rd_en0      = beat & ~sel_q;
   assign rd_en1      = beat & sel_q;
   assign rd_idx      = cnt_q;
   assign busy        = (state_q != IDLE);
   assign AXI_raddr   = raddr_q;
   assign AXI_arlen   = LAST_IDX;
   assign AXI_arvalid = arvalid_q;
   assign AXI_rready  = rready_q;

endmodule

// File: tb/tb_a2s_rd_arbiter.sv
// Bench for a2s_rd_arbiter: a table of burst records drives a small AXI slave;
// every offered R beat pushes the expected {channel, index} onto a scoreboard
// that is popped when the DUT raises a strobe. Reset mid-burst is hand-written.
module tb_a2s_rd_arbiter;

   logic        AXI_clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0, req1;
   logic [31:0] req_addr0, req_addr1;
   logic        gnt0, gnt1, rd_en0, rd_en1, done0, done1, err0, err1, busy;
   logic [3:0]  rd_idx;
   logic [31:0] AXI_raddr;
   logic [3:0]  AXI_arlen;
   logic        AXI_arvalid, AXI_arready, AXI_rvalid, AXI_rlast, AXI_rready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 AXI_clk = ~AXI_clk;

   a2s_rd_arbiter #(.BURST_LEN(16), .ADDR_ALIGN(2)) dut (
      .AXI_clk     (AXI_clk),
      .rst         (rst),
      .req0        (req0),
      .req1        (req1),
      .req_addr0   (req_addr0),
      .req_addr1   (req_addr1),
      .gnt0        (gnt0),
      .gnt1        (gnt1),
      .rd_en0      (rd_en0),
      .rd_en1      (rd_en1),
      .rd_idx      (rd_idx),
      .done0       (done0),
      .done1       (done1),
      .err0        (err0),
      .err1        (err1),
      .busy        (busy),
      .AXI_raddr   (AXI_raddr),
      .AXI_arlen   (AXI_arlen),
      .AXI_arvalid (AXI_arvalid),
      .AXI_arready (AXI_arready),
      .AXI_rvalid  (AXI_rvalid),
      .AXI_rlast   (AXI_rlast),
      .AXI_rready  (AXI_rready)
   );

   // One burst: request levels, slave behaviour and the expected outcome.
   typedef struct {
      logic        req0;
      logic        req1;
      logic [31:0] addr0;
      logic [31:0] addr1;
      int          ar_delay;    // cycles arready is held low after arvalid
      logic        gap;         // rvalid toggles 1/0
      int          rlast_beat;  // beat carrying rlast, 16 = never
      logic        hold;        // keep requests high after grant
      int          exp_lat;     // sampled cycles from drive to arvalid
      logic        exp_ch;
      logic [31:0] exp_addr;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic       ch;
      logic [3:0] idx;
   } beat_t;

   vec_t  vecs[9];
   beat_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Waits (bounded) for arvalid; n counts the clock edges it took.
   task automatic wait_arvalid(output int n, output logic ok);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge AXI_clk);
         n = i;
         if (AXI_arvalid) begin
            ok = 1'b1;
            break;
         end
         @(posedge AXI_clk); #1;
      end
   endtask

   task automatic run_burst(input vec_t v);
      int    n;
      int    k;
      int    last_k;
      int    cyc;
      logic  ok;
      logic  send;
      beat_t e;
      logic [1:0] one_hot;

      one_hot = v.exp_ch ? 2'b10 : 2'b01;
      @(posedge AXI_clk); #1;
      req0 = v.req0; req1 = v.req1;
      req_addr0 = v.addr0; req_addr1 = v.addr1;
      AXI_arready = 1'b0; AXI_rvalid = 1'b0; AXI_rlast = 1'b0;

      wait_arvalid(n, ok);
      if (!ok) begin
         fail_now("arvalid_timeout");
         return;
      end
      check("ar_latency", n, v.exp_lat);
      check("raddr", AXI_raddr, v.exp_addr);
      check("arlen", {28'd0, AXI_arlen}, 32'd15);

      // Address phase stalls; stray rvalid must be ignored meanwhile.
      for (int d = 0; d < v.ar_delay; d++) begin
         @(posedge AXI_clk); #1;
         AXI_rvalid = 1'b1;
         @(negedge AXI_clk);
         check("arvalid_hold", AXI_arvalid, 1);
         check("raddr_hold", AXI_raddr, v.exp_addr);
         check("rd_en_in_addr", {rd_en1, rd_en0}, 0);
      end
      @(posedge AXI_clk); #1;
      AXI_arready = 1'b1;
      @(posedge AXI_clk); #1;
      AXI_arready = 1'b0;
      AXI_rvalid  = 1'b0;
      @(negedge AXI_clk);
      check("gnt", {gnt1, gnt0}, one_hot);
      check("arvalid_after_hs", AXI_arvalid, 0);
      check("rready_in_data", AXI_rready, 1);
      if (!v.hold) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end

      // Data phase: push an expectation for every offered beat.
      last_k = (v.rlast_beat < 16) ? v.rlast_beat : 15;
      k = 0;
      cyc = 0;
      while (k <= last_k && cyc < 64) begin
         @(posedge AXI_clk); #1;
         send = !(v.gap && cyc[0]);
         AXI_rvalid = send;
         AXI_rlast  = send && (k == v.rlast_beat);
         if (send) sb.push_back('{v.exp_ch, 4'(k)});
         @(negedge AXI_clk);
         if (cyc == 0) check("gnt_one_cycle", {gnt1, gnt0}, 0);
         check("other_rd_en", v.exp_ch ? rd_en0 : rd_en1, 0);
         if (rd_en0 | rd_en1) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_strobe");
            end else begin
               e = sb.pop_front();
               check("strobe_ch", rd_en1, e.ch);
               check("rd_idx", rd_idx, e.idx);
            end
         end
         if (send) k++;
         cyc++;
      end

      @(posedge AXI_clk); #1;
      AXI_rvalid = 1'b0;
      AXI_rlast  = 1'b0;
      @(negedge AXI_clk);
      check("done", {done1, done0}, one_hot);
      check("err", {err1, err0}, v.exp_err ? one_hot : 2'b00);
      check("rready_after", AXI_rready, 0);
      check("busy_after", busy, 0);
      check("missing_strobes", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   n;
      logic ok;

      //          req0 req1 addr0          addr1          ard gap rl  hold lat ch  exp_addr       err
      vecs[0] = '{1'b1, 1'b0, 32'hFFFC_0043, 32'h0,         0, 1'b0, 15, 1'b0, 1, 1'b0, 32'hFFFC_0040, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h0,         32'h1000_0002, 5, 1'b1, 15, 1'b0, 1, 1'b1, 32'h1000_0000, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h2000_0007, 32'h3000_0001, 0, 1'b0, 15, 1'b1, 1, 1'b0, 32'h2000_0004, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'h2000_0007, 32'h3000_0001, 0, 1'b0, 15, 1'b1, 0, 1'b1, 32'h3000_0000, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'h2000_0007, 32'h3000_0001, 0, 1'b0, 15, 1'b1, 0, 1'b0, 32'h2000_0004, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 32'h2000_0007, 32'h3000_0001, 0, 1'b0, 15, 1'b0, 0, 1'b1, 32'h3000_0000, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0105, 32'h0,         0, 1'b0,  9, 1'b0, 1, 1'b0, 32'h0000_0104, 1'b1};
      vecs[7] = '{1'b0, 1'b1, 32'h0,         32'hABCD_EF0F, 0, 1'b0, 16, 1'b0, 1, 1'b1, 32'hABCD_EF0C, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,         2, 1'b1, 15, 1'b0, 1, 1'b0, 32'h0000_0000, 1'b0};

      req0 = 1'b0; req1 = 1'b0; req_addr0 = 32'd0; req_addr1 = 32'd0;
      AXI_arready = 1'b0; AXI_rvalid = 1'b0; AXI_rlast = 1'b0;

      // Reset state.
      #1 rst = 1'b1;
      #2;
      check("rst_arvalid", AXI_arvalid, 0);
      check("rst_raddr", AXI_raddr, 0);
      check("rst_busy", busy, 0);
      check("rst_rready", AXI_rready, 0);
      check("rst_pulses", {gnt1, gnt0, done1, done0, err1, err0, rd_en1, rd_en0}, 0);
      check("rst_rd_idx", rd_idx, 0);
      repeat (3) @(posedge AXI_clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 9; i++) run_burst(vecs[i]);

      // Reset asserted between clock edges while beat 7 of a CH0 burst is on the bus.
      @(posedge AXI_clk); #1;
      req0 = 1'b1; req1 = 1'b0; req_addr0 = 32'h4000_0003; AXI_arready = 1'b1;
      wait_arvalid(n, ok);
      if (!ok) fail_now("arvalid_timeout_rst_seq");
      @(posedge AXI_clk); #1;
      AXI_arready = 1'b0;
      req0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge AXI_clk); #1;
         AXI_rvalid = 1'b1;
         @(negedge AXI_clk);
      end
      check("pre_rst_rd_en0", rd_en0, 1);
      check("pre_rst_rd_idx", rd_idx, 7);
      #1 rst = 1'b1;
      #1;
      check("midrst_rd_en", {rd_en1, rd_en0}, 0);
      check("midrst_rd_idx", rd_idx, 0);
      check("midrst_busy", busy, 0);
      check("midrst_rready", AXI_rready, 0);
      check("midrst_raddr", AXI_raddr, 0);
      check("midrst_arvalid", AXI_arvalid, 0);
      @(posedge AXI_clk); #1;
      rst = 1'b0;
      AXI_rvalid = 1'b0;

      // rr_ptr is back at CH0, so a tie goes to CH0.
      @(posedge AXI_clk); #1;
      req0 = 1'b1; req1 = 1'b1;
      req_addr0 = 32'h5000_0001; req_addr1 = 32'h6000_0002;
      wait_arvalid(n, ok);
      if (!ok) begin
         fail_now("arvalid_timeout_post_rst");
      end else begin
         check("post_rst_latency", n, 1);
         check("post_rst_raddr", AXI_raddr, 32'h5000_0000);
         @(posedge AXI_clk); #1;
         AXI_arready = 1'b1;
         @(posedge AXI_clk); #1;
         AXI_arready = 1'b0;
         req0 = 1'b0; req1 = 1'b0;
         @(negedge AXI_clk);
         check("post_rst_gnt", {gnt1, gnt0}, 2'b01);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
